// File: rtl/ripemd160_msg_padder_pkg.sv
// Shared types and constants for the RIPEMD-160 message padder.
// Blocks are 64 bytes; the 64-bit length field starts at byte 56.
package ripemd160_msg_padder_pkg;

   typedef enum logic [1:0] {
      ABSORB,
      PAD,
      LEN,
      EMIT
   } state_t;

   localparam int         BLOCK_BYTES = 64;
   localparam int         LEN_OFFSET  = 56;
   localparam logic [7:0] PAD_BYTE    = 8'h80;
   localparam int         WORD_W      = 32;

endpackage

// File: rtl/ripemd160_msg_padder_if.sv
// Byte stream in, 512-bit block out, both with valid/ready handshakes.
// The slave side is the padder; the master side is the producer plus the block consumer.
interface ripemd160_msg_padder_if;
   import ripemd160_msg_padder_pkg::*;

   logic [7:0]           in_data;
   logic                 in_valid;
   logic                 in_last;
   logic                 in_ready;
   logic                 empty_req;
   logic [16*WORD_W-1:0] blk_data;
   logic                 blk_valid;
   logic                 blk_last;
   logic                 blk_ready;

   modport master (
      output in_data, in_valid, in_last, empty_req, blk_ready,
      input  in_ready, blk_data, blk_valid, blk_last
   );

   modport slave (
      input  in_data, in_valid, in_last, empty_req, blk_ready,
      output in_ready, blk_data, blk_valid, blk_last
   );

endinterface

// File: rtl/ripemd160_msg_padder.sv
// RIPEMD-160 front end: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and the 64-bit little-endian bit length.
//
// state  | meaning
// ABSORB | accept message bytes into the block buffer (in_ready=1)
// PAD    | write the 0x80 marker at pos (one cycle)
// LEN    | write the bit length into X[14]/X[15] (one cycle)
// EMIT   | hold the block on blk_data until blk_ready
module ripemd160_msg_padder
   import ripemd160_msg_padder_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input logic                   clk,
   input logic                   rst,
   ripemd160_msg_padder_if.slave bus
);

   localparam logic [5:0] LAST_POS = 6'(BLOCK_BYTES - 1);

   state_t           state_q;
   logic [5:0]       pos_q;
   logic [LEN_W-1:0] len_q;
   logic             pend_q;
   // set: the deferred work is the 0x80 marker; clear: only the length is deferred
   logic             pend_pad_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ABSORB;
         pos_q         <= '0;
         len_q         <= '0;
         pend_q        <= 1'b0;
         pend_pad_q    <= 1'b0;
         bus.blk_data  <= '0;
         bus.blk_valid <= 1'b0;
         bus.blk_last  <= 1'b0;
         bus.in_ready  <= 1'b1;
      end else begin
         case (state_q)
            ABSORB: begin
               if (bus.in_valid) begin
                  bus.blk_data[{pos_q, 3'b000} +: 8] <= bus.in_data;
                  len_q <= len_q + LEN_W'(8);
                  if (pos_q == LAST_POS) begin
                     state_q       <= EMIT;
                     bus.blk_valid <= 1'b1;
                     bus.blk_last  <= 1'b0;
                     bus.in_ready  <= 1'b0;
                     pend_q        <= bus.in_last;
                     pend_pad_q    <= bus.in_last;
                  end else begin
                     pos_q <= pos_q + 6'd1;
                     if (bus.in_last) begin
                        state_q      <= PAD;
                        bus.in_ready <= 1'b0;
                     end
                  end
               end else if (bus.empty_req && pos_q == '0 && len_q == '0) begin
                  state_q      <= PAD;
                  bus.in_ready <= 1'b0;
               end
            end
            PAD: begin
               bus.blk_data[{pos_q, 3'b000} +: 8] <= PAD_BYTE;
               pos_q <= pos_q + 6'd1;
               if (pos_q < 6'(LEN_OFFSET)) begin
                  state_q <= LEN;
               end else begin
                  state_q       <= EMIT;
                  bus.blk_valid <= 1'b1;
                  bus.blk_last  <= 1'b0;
                  pend_q        <= 1'b1;
                  pend_pad_q    <= 1'b0;
               end
            end
            LEN: begin
               bus.blk_data[LEN_OFFSET*8 +: 2*WORD_W] <= 64'(len_q);
               state_q       <= EMIT;
               bus.blk_valid <= 1'b1;
               bus.blk_last  <= 1'b1;
            end
            EMIT: begin
               if (bus.blk_ready) begin
                  bus.blk_data  <= '0;
                  pos_q         <= '0;
                  bus.blk_valid <= 1'b0;
                  bus.blk_last  <= 1'b0;
                  if (bus.blk_last) begin
                     len_q        <= '0;
                     state_q      <= ABSORB;
                     bus.in_ready <= 1'b1;
                  end else if (pend_q) begin
                     pend_q  <= 1'b0;
                     state_q <= pend_pad_q ? PAD : LEN;
                  end else begin
                     state_q      <= ABSORB;
                     bus.in_ready <= 1'b1;
                  end
               end
            end
            default: state_q <= ABSORB;
         endcase
      end
   end

endmodule
